// File: rtl/axi_lite_regbus_bridge_if.sv
// Bundles the AXI4-Lite slave channels and the register-bus initiator signals
// of the bridge; the slave modport is the bridge view, master the environment view.
interface axi_lite_regbus_bridge_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 12,
   parameter int MEM_W  = 10
);
   logic [ADDR_W-1:0]   s_axi_awaddr;
   logic                s_axi_awvalid;
   logic                s_axi_awready;
   logic [DATA_W-1:0]   s_axi_wdata;
   logic [DATA_W/8-1:0] s_axi_wstrb;
   logic                s_axi_wvalid;
   logic                s_axi_wready;
   logic [1:0]          s_axi_bresp;
   logic                s_axi_bvalid;
   logic                s_axi_bready;
   logic [ADDR_W-1:0]   s_axi_araddr;
   logic                s_axi_arvalid;
   logic                s_axi_arready;
   logic [DATA_W-1:0]   s_axi_rdata;
   logic [1:0]          s_axi_rresp;
   logic                s_axi_rvalid;
   logic                s_axi_rready;
   logic                wen;
   logic [DATA_W/8-1:0] wstrb;
   logic [MEM_W-1:0]    waddr;
   logic [DATA_W-1:0]   wdata;
   logic                ren;
   logic [MEM_W-1:0]    raddr;
   logic [DATA_W-1:0]   rdata;

   modport slave (
      input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
      input  s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready, rdata,
      output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
      output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
      output wen, wstrb, waddr, wdata, ren, raddr
   );

   modport master (
      output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
      output s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready, rdata,
      input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
      input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
      input  wen, wstrb, waddr, wdata, ren, raddr
   );
endinterface

// File: rtl/axi_lite_regbus_bridge.sv
// AXI4-Lite slave that turns each write/read into a single-cycle register-bus strobe,
// holding off new reads while a write is being strobed and committed by the bank.
module axi_lite_regbus_bridge #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 12,
   parameter int OPT_MEM_ADDR_BITS  = 10,
   parameter int ADDR_LSB           = 2
) (
   input logic                     clk,
   input logic                     rst_n,
   axi_lite_regbus_bridge_if.slave bus
);
   localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

   typedef enum logic [1:0] {W_IDLE, W_STROBE, W_COMMIT, W_RESP} wState_e;
   typedef enum logic [1:0] {R_IDLE, R_STROBE, R_WAIT, R_DATA} rState_e;

   wState_e                        wState_q, wState_d;
   rState_e                        rState_q, rState_d;
   logic                           awHeld_q, awHeld_d;
   logic                           wHeld_q, wHeld_d;
   logic [OPT_MEM_ADDR_BITS-1:0]   awAddr_q, awAddr_d;
   logic [C_S_AXI_DATA_WIDTH-1:0]  wData_q, wData_d;
   logic [STRB_W-1:0]              wStrb_q, wStrb_d;
   logic [OPT_MEM_ADDR_BITS-1:0]   arAddr_q, arAddr_d;
   logic [C_S_AXI_DATA_WIDTH-1:0]  rData_q, rData_d;

   logic awReady, wReady, bValid, wenInt, writeGo;
   logic arReady, rValid, renInt;

   // Only the word-address slice matters; the remaining bits alias by design.
   logic unusedAddrBits;
   assign unusedAddrBits = ^{bus.s_axi_awaddr, bus.s_axi_araddr};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wState_q <= W_IDLE;
         rState_q <= R_IDLE;
         awHeld_q <= 1'b0;
         wHeld_q  <= 1'b0;
         awAddr_q <= '0;
         wData_q  <= '0;
         wStrb_q  <= '0;
         arAddr_q <= '0;
         rData_q  <= '0;
      end else begin
         wState_q <= wState_d;
         rState_q <= rState_d;
         awHeld_q <= awHeld_d;
         wHeld_q  <= wHeld_d;
         awAddr_q <= awAddr_d;
         wData_q  <= wData_d;
         wStrb_q  <= wStrb_d;
         arAddr_q <= arAddr_d;
         rData_q  <= rData_d;
      end
   end

   // Readies are qualified with rst_n so that nothing looks ready while reset is held.
   always_comb begin
      wState_d = wState_q;
      awHeld_d = awHeld_q;
      wHeld_d  = wHeld_q;
      awAddr_d = awAddr_q;
      wData_d  = wData_q;
      wStrb_d  = wStrb_q;
      awReady  = 1'b0;
      wReady   = 1'b0;
      bValid   = 1'b0;
      wenInt   = 1'b0;
      writeGo  = 1'b0;
      case (wState_q)
         W_IDLE: begin
            awReady = rst_n && !awHeld_q;
            wReady  = rst_n && !wHeld_q;
            if (awReady && bus.s_axi_awvalid) begin
               awHeld_d = 1'b1;
               awAddr_d = bus.s_axi_awaddr[ADDR_LSB +: OPT_MEM_ADDR_BITS];
            end
            if (wReady && bus.s_axi_wvalid) begin
               wHeld_d = 1'b1;
               wData_d = bus.s_axi_wdata;
               wStrb_d = bus.s_axi_wstrb;
            end
            if (awHeld_d && wHeld_d) begin
               writeGo   = 1'b1;
               wState_d  = W_STROBE;
            end
         end
         W_STROBE: begin
            wenInt   = 1'b1;
            wState_d = W_COMMIT;
         end
         W_COMMIT: begin
            wState_d = W_RESP;
         end
         W_RESP: begin
            bValid = 1'b1;
            if (bus.s_axi_bready) begin
               awHeld_d = 1'b0;
               wHeld_d  = 1'b0;
               wState_d = W_IDLE;
            end
         end
         default: wState_d = W_IDLE;
      endcase
   end

   // A read may only start when no write is about to strobe or still committing.
   always_comb begin
      rState_d = rState_q;
      arAddr_d = arAddr_q;
      rData_d  = rData_q;
      arReady  = 1'b0;
      rValid   = 1'b0;
      renInt   = 1'b0;
      case (rState_q)
         R_IDLE: begin
            arReady = rst_n && ((wState_q == W_RESP) || ((wState_q == W_IDLE) && !writeGo));
            if (arReady && bus.s_axi_arvalid) begin
               arAddr_d = bus.s_axi_araddr[ADDR_LSB +: OPT_MEM_ADDR_BITS];
               rState_d = R_STROBE;
            end
         end
         R_STROBE: begin
            renInt   = 1'b1;
            rState_d = R_WAIT;
         end
         R_WAIT: begin
            rData_d  = bus.rdata;
            rState_d = R_DATA;
         end
         R_DATA: begin
            rValid = 1'b1;
            if (bus.s_axi_rready) begin
               rState_d = R_IDLE;
            end
         end
         default: rState_d = R_IDLE;
      endcase
   end

   assign bus.s_axi_awready = awReady;
   assign bus.s_axi_wready  = wReady;
   assign bus.s_axi_bvalid  = bValid;
   assign bus.s_axi_bresp   = 2'b00;
   assign bus.s_axi_arready = arReady;
   assign bus.s_axi_rvalid  = rValid;
   assign bus.s_axi_rresp   = 2'b00;
   assign bus.s_axi_rdata   = rData_q;
   assign bus.wen           = wenInt;
   assign bus.waddr         = awAddr_q;
   assign bus.wdata         = wData_q;
   assign bus.wstrb         = wStrb_q;
   assign bus.ren           = renInt;
   assign bus.raddr         = arAddr_q;
endmodule

// File: tb/tb_axi_lite_regbus_bridge.sv
// Directed bench for the AXI4-Lite to register-bus bridge with a registered bank model,
// a reference memory and scoreboard queues for expected strobes and read data.
module tb_axi_lite_regbus_bridge;
   logic clk;
   logic rst_n;
   int   totalChecks = 0;
   int   badChecks   = 0;
   int   cycleCount  = 0;
   int   wenCount    = 0;
   int   wenCycle    = 0;
   int   rHsCount    = 0;

   logic [45:0] wrQ[$];
   logic [9:0]  raddrQ[$];
   logic [31:0] rdQ[$];
   logic [31:0] refMem [1024];

   logic        pendValid;
   logic [9:0]  pendAddr;
   logic [31:0] pendData;
   logic [3:0]  pendStrb;
   logic [31:0] bankMem [1024];

   axi_lite_regbus_bridge_if #(.DATA_W(32), .ADDR_W(13), .MEM_W(10)) bus ();

   axi_lite_regbus_bridge #(
      .C_S_AXI_DATA_WIDTH(32),
      .C_S_AXI_ADDR_WIDTH(13),
      .OPT_MEM_ADDR_BITS (10),
      .ADDR_LSB          (2)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycleCount <= cycleCount + 1;

   function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] data,
                                              input logic [3:0] strb);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = data[b*8 +: 8];
      return r;
   endfunction

   function automatic logic [9:0] wordOf(input logic [12:0] a);
      return a[11:2];
   endfunction

   // Register bank: writes land one cycle after the wen edge, reads are registered.
   always @(posedge clk) begin
      pendValid <= bus.wen;
      pendAddr  <= bus.waddr;
      pendData  <= bus.wdata;
      pendStrb  <= bus.wstrb;
      if (pendValid) bankMem[pendAddr] <= mergeBytes(bankMem[pendAddr], pendData, pendStrb);
      if (bus.ren) bus.rdata <= bankMem[bus.raddr];
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      totalChecks++;
      assert (observed === expected) else begin
         badChecks++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Strobe monitors pop the scoreboard entries pushed when the transaction was issued.
   always @(negedge clk) begin
      if (rst_n && bus.wen) begin
         wenCount <= wenCount + 1;
         wenCycle <= cycleCount;
         checkOutput("wen_pending", 64'(wrQ.size() > 0), 64'd1);
         if (wrQ.size() > 0) checkOutput("wen_fields", {bus.waddr, bus.wdata, bus.wstrb}, wrQ.pop_front());
      end
      if (rst_n && bus.ren) begin
         checkOutput("ren_pending", 64'(raddrQ.size() > 0), 64'd1);
         if (raddrQ.size() > 0) checkOutput("ren_raddr", bus.raddr, raddrQ.pop_front());
      end
      if (bus.s_axi_rvalid && bus.s_axi_rready) rHsCount <= rHsCount + 1;
   end

   task automatic applyStimulus(input logic [12:0] addr, input logic [31:0] data,
                                input logic [3:0] strb, input int wLead, input int bDelay,
                                output int awCyc, output int wCyc, output int bvCyc);
      logic awPending, wPending, aF, wF, seen;
      int   wenBefore;
      @(posedge clk); #1;
      wrQ.push_back({wordOf(addr), data, strb});
      refMem[wordOf(addr)] = mergeBytes(refMem[wordOf(addr)], data, strb);
      wenBefore = wenCount;
      awCyc = -1; wCyc = -1; bvCyc = -1;
      bus.s_axi_awaddr  = addr;
      bus.s_axi_wdata   = data;
      bus.s_axi_wstrb   = strb;
      bus.s_axi_wvalid  = 1'b1;
      bus.s_axi_awvalid = (wLead == 0);
      awPending = 1'b1; wPending = 1'b1;
      for (int c = 0; c < 60 && (awPending || wPending); c++) begin
         @(negedge clk);
         aF = bus.s_axi_awvalid && bus.s_axi_awready;
         wF = bus.s_axi_wvalid && bus.s_axi_wready;
         if (aF) awCyc = cycleCount;
         if (wF) wCyc = cycleCount;
         @(posedge clk); #1;
         if (aF) begin bus.s_axi_awvalid = 1'b0; awPending = 1'b0; end
         if (wF) begin bus.s_axi_wvalid = 1'b0; wPending = 1'b0; end
         if (awPending && (c + 1 >= wLead)) bus.s_axi_awvalid = 1'b1;
      end
      bus.s_axi_awvalid = 1'b0;
      bus.s_axi_wvalid  = 1'b0;
      checkOutput("aw_w_done", {awPending, wPending}, 2'b00);
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(negedge clk);
         if (bus.s_axi_bvalid) begin seen = 1'b1; bvCyc = cycleCount; end
      end
      checkOutput("bvalid_seen", seen, 1'b1);
      checkOutput("bresp", bus.s_axi_bresp, 2'b00);
      checkOutput("b_latency", bvCyc - ((awCyc > wCyc) ? awCyc : wCyc), 3);
      for (int d = 0; d < bDelay; d++) begin
         @(posedge clk); #1;
         @(negedge clk);
         checkOutput("bvalid_held", {bus.s_axi_bvalid, bus.s_axi_bresp}, 3'b100);
      end
      @(posedge clk); #1 bus.s_axi_bready = 1'b1;
      @(posedge clk); #1 bus.s_axi_bready = 1'b0;
      @(negedge clk);
      checkOutput("bvalid_clear", bus.s_axi_bvalid, 1'b0);
      checkOutput("wen_once", wenCount - wenBefore, 1);
      checkOutput("wen_latency", wenCycle - ((awCyc > wCyc) ? awCyc : wCyc), 1);
   endtask

   task automatic applyRead(input logic [12:0] addr, input int rDelay, output int arCyc);
      logic        seen;
      logic [31:0] held;
      int          rvCyc, hsBefore;
      @(posedge clk); #1;
      arCyc = -1; rvCyc = -1;
      bus.s_axi_araddr  = addr;
      bus.s_axi_arvalid = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 60 && !seen; c++) begin
         @(negedge clk);
         if (bus.s_axi_arready) begin
            seen  = 1'b1;
            arCyc = cycleCount;
            rdQ.push_back(refMem[wordOf(addr)]);
            raddrQ.push_back(wordOf(addr));
         end
      end
      @(posedge clk); #1 bus.s_axi_arvalid = 1'b0;
      checkOutput("ar_handshake", seen, 1'b1);
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         if (c > 0) @(negedge clk);
         if (bus.s_axi_rvalid) begin seen = 1'b1; rvCyc = cycleCount; end
      end
      checkOutput("rvalid_seen", seen, 1'b1);
      checkOutput("r_latency", rvCyc - arCyc, 3);
      held = bus.s_axi_rdata;
      for (int d = 0; d < rDelay; d++) begin
         @(posedge clk); #1;
         @(negedge clk);
         checkOutput("r_hold", {bus.s_axi_rvalid, bus.s_axi_rresp, bus.s_axi_rdata}, {1'b1, 2'b00, held});
      end
      hsBefore = rHsCount;
      @(posedge clk); #1 bus.s_axi_rready = 1'b1;
      @(negedge clk);
      checkOutput("rdata_pending", 64'(rdQ.size() > 0), 64'd1);
      if (rdQ.size() > 0) checkOutput("rdata", bus.s_axi_rdata, rdQ.pop_front());
      @(posedge clk); #1 bus.s_axi_rready = 1'b0;
      @(negedge clk);
      checkOutput("rvalid_clear", bus.s_axi_rvalid, 1'b0);
      checkOutput("r_hs_once", rHsCount - hsBefore, 1);
   endtask

   initial begin
      int awC, wC, bvC, arC, bvA, arA, awD, wD;
      rst_n = 1'b0;
      bus.s_axi_awaddr = '0; bus.s_axi_awvalid = 1'b0;
      bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0; bus.s_axi_wvalid = 1'b0;
      bus.s_axi_bready = 1'b0;
      bus.s_axi_araddr = '0; bus.s_axi_arvalid = 1'b0;
      bus.s_axi_rready = 1'b0;
      #3;
      checkOutput("reset_ready", {bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}, 3'b000);
      checkOutput("reset_valid", {bus.s_axi_bvalid, bus.s_axi_rvalid, bus.wen, bus.ren}, 4'b0000);
      checkOutput("reset_bus", {bus.waddr, bus.wdata, bus.wstrb, bus.raddr}, 64'd0);
      checkOutput("reset_rdata", bus.s_axi_rdata, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      $display("[TB] write 0x000 then read back");
      applyStimulus(13'h000, 32'h0000_0003, 4'hF, 0, 0, awC, wC, bvC);
      applyRead(13'h000, 0, arC);

      $display("[TB] W leads AW by 3 cycles");
      applyStimulus(13'h024, 32'h0000_0024, 4'hF, 3, 0, awC, wC, bvC);
      checkOutput("w_before_aw", 64'(wC < awC), 64'd1);

      $display("[TB] read with rready backpressure");
      applyStimulus(13'h030, 32'hA5A5_1234, 4'hF, 0, 2, awC, wC, bvC);
      applyRead(13'h030, 5, arC);

      $display("[TB] AR collides with write completion");
      applyStimulus(13'h004, 32'h0000_0006, 4'hF, 0, 0, awC, wC, bvC);
      fork
         applyStimulus(13'h004, 32'h0000_0005, 4'hF, 0, 0, awD, wD, bvA);
         applyRead(13'h004, 0, arA);
      join
      checkOutput("ar_waits_for_b", arA, bvA);

      $display("[TB] aliased address with partial strobe");
      applyStimulus(13'h1004, 32'hDEAD_BE77, 4'b0001, 0, 0, awC, wC, bvC);
      applyRead(13'h004, 0, arC);

      $display("[TB] reset during W_COMMIT");
      @(posedge clk); #1;
      wrQ.push_back({wordOf(13'h0AC), 32'h1122_3344, 4'hF});
      refMem[wordOf(13'h0AC)] = 32'h1122_3344;
      bus.s_axi_awaddr = 13'h0AC; bus.s_axi_wdata = 32'h1122_3344; bus.s_axi_wstrb = 4'hF;
      bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1;
      @(negedge clk);
      checkOutput("rst_w_accept", {bus.s_axi_awready, bus.s_axi_wready}, 2'b11);
      @(posedge clk); #1;
      bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
      @(posedge clk); #1 rst_n = 1'b0;
      #1 checkOutput("rst_w_outputs", {bus.s_axi_bvalid, bus.wen, bus.s_axi_awready, bus.s_axi_wready}, 4'b0000);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checkOutput("rst_w_dropped", bus.s_axi_bvalid, 1'b0);
      end

      $display("[TB] reset during R_DATA");
      @(posedge clk); #1;
      bus.s_axi_araddr = 13'h030; bus.s_axi_arvalid = 1'b1;
      @(negedge clk);
      checkOutput("rst_r_accept", bus.s_axi_arready, 1'b1);
      raddrQ.push_back(wordOf(13'h030));
      @(posedge clk); #1 bus.s_axi_arvalid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      checkOutput("rst_r_in_data", bus.s_axi_rvalid, 1'b1);
      rst_n = 1'b0;
      #1 checkOutput("rst_r_outputs", {bus.s_axi_rvalid, bus.ren, bus.s_axi_arready, bus.s_axi_rdata}, 35'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      $display("[TB] fresh traffic after reset");
      applyStimulus(13'h0B0, 32'h5566_7788, 4'hF, 0, 0, awC, wC, bvC);
      applyRead(13'h0B0, 1, arC);

      checkOutput("wrq_empty", wrQ.size(), 0);
      checkOutput("raddrq_empty", raddrQ.size(), 0);
      checkOutput("rdq_empty", rdQ.size(), 0);
      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end
endmodule
